sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 34 +++
 rtl/sram_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - two requester ports plus SRAM pin bundle for sram_arbiter
interface sram_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [17:0] a_addr;
    logic [7:0]  a_wdata;
    logic        a_ack;
    logic [7:0]  a_rdata;

    logic        b_req;
    logic        b_we;
    logic [17:0] b_addr;
    logic [7:0]  b_wdata;
    logic        b_ack;
    logic [7:0]  b_rdata;

    logic        RAMCS_b;
    logic        RAMOE_b;
    logic        RAMWE_b;
    logic [17:0] ADR;
    logic [7:0]  dat_out;
    logic        dat_oe;
    logic [7:0]  dat_in;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, dat_in,
        output a_ack, a_rdata, b_ack, b_rdata, RAMCS_b, RAMOE_b, RAMWE_b, ADR, dat_out, dat_oe
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, dat_in,
        input  a_ack, a_rdata, b_ack, b_rdata, RAMCS_b, RAMOE_b, RAMWE_b, ADR, dat_out, dat_oe
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port async SRAM arbiter with A priority and B anti-starvation
module sram_arbiter #(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 3,
    parameter int STARVE    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_WHOLD} state_t;

    localparam logic [3:0] LP_RD_LAST = 4'(RD_CYCLES - 1);
    localparam logic [3:0] LP_WR_LAST = 4'(WR_CYCLES - 1);
    localparam logic [3:0] LP_STARVE  = 4'(STARVE);

    state_t      r_state;
    logic [3:0]  r_phase;
    logic [3:0]  r_starve;
    logic        r_sel_b;
    logic        r_cs_b;
    logic        r_oe_b;
    logic        r_we_b;
    logic [17:0] r_adr;
    logic [7:0]  r_dout;
    logic        r_dat_oe;
    logic        r_a_ack;
    logic        r_b_ack;
    logic [7:0]  r_a_rdata;
    logic [7:0]  r_b_rdata;

    logic        w_a_pend;
    logic        w_b_pend;
    logic        w_pick_b;
    logic        w_go;
    logic        w_we;
    logic [17:0] w_addr;
    logic [7:0]  w_wdata;

    // The ack cycle is a dead arbitration cycle: a requester still holding req
    // through its ack is not re-granted, and both ports re-arbitrate afterwards.
    assign w_a_pend = bus.a_req & ~r_a_ack & ~r_b_ack;
    assign w_b_pend = bus.b_req & ~r_a_ack & ~r_b_ack;
    assign w_pick_b = w_b_pend & (~w_a_pend | (r_starve == LP_STARVE));
    assign w_go     = w_a_pend | w_b_pend;
    assign w_we     = w_pick_b ? bus.b_we    : bus.a_we;
    assign w_addr   = w_pick_b ? bus.b_addr  : bus.a_addr;
    assign w_wdata  = w_pick_b ? bus.b_wdata : bus.a_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_starve  <= '0;
            r_sel_b   <= 1'b0;
            r_cs_b    <= 1'b1;
            r_oe_b    <= 1'b1;
            r_we_b    <= 1'b1;
            r_adr     <= '0;
            r_dout    <= '0;
            r_dat_oe  <= 1'b0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_sel_b <= w_pick_b;
                        r_adr   <= w_addr;
                        r_phase <= '0;
                        r_cs_b  <= 1'b0;
                        if (w_we) begin
                            r_dout   <= w_wdata;
                            r_we_b   <= 1'b0;
                            r_dat_oe <= 1'b1;
                            r_state  <= S_WRITE;
                        end else begin
                            r_oe_b  <= 1'b0;
                            r_state <= S_READ;
                        end
                        if (w_pick_b || !bus.b_req)
                            r_starve <= '0;
                        else if (r_starve != LP_STARVE)
                            r_starve <= r_starve + 4'd1;
                    end
                end
                S_READ: begin
                    if (r_phase == LP_RD_LAST) begin
                        if (r_sel_b) begin
                            r_b_rdata <= bus.dat_in;
                            r_b_ack   <= 1'b1;
                        end else begin
                            r_a_rdata <= bus.dat_in;
                            r_a_ack   <= 1'b1;
                        end
                        r_cs_b  <= 1'b1;
                        r_oe_b  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_phase <= r_phase + 4'd1;
                    end
                end
                S_WRITE: begin
                    if (r_phase == LP_WR_LAST) begin
                        r_we_b  <= 1'b1;
                        r_state <= S_WHOLD;
                    end else begin
                        r_phase <= r_phase + 4'd1;
                    end
                end
                S_WHOLD: begin
                    r_cs_b   <= 1'b1;
                    r_dat_oe <= 1'b0;
                    r_a_ack  <= ~r_sel_b;
                    r_b_ack  <= r_sel_b;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.RAMCS_b = r_cs_b;
    assign bus.RAMOE_b = r_oe_b;
    assign bus.RAMWE_b = r_we_b;
    assign bus.ADR     = r_adr;
    assign bus.dat_out = r_dout;
    assign bus.dat_oe  = r_dat_oe;
    assign bus.a_ack   = r_a_ack;
    assign bus.b_ack   = r_b_ack;
    assign bus.a_rdata = r_a_rdata;
    assign bus.b_rdata = r_b_rdata;
endmodule
